// File: rtl/interrupt_controller_n_if.sv
// interrupt_controller_n_if: peripheral/CPU-side signal bundle of the interrupt controller
interface interrupt_controller_n_if #(
    parameter int NUM_SRC = 8,
    parameter int IDW = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] int_sources;
    logic [NUM_SRC-1:0] int_enable;
    logic ea;
    logic [NUM_SRC-1:0] edge_mode;
    logic int_ack_attended;
    logic int_ack_complete;
    logic int_req;
    logic [IDW-1:0] int_number;
    logic int_pending;
    logic int_attending;
    logic [NUM_SRC-1:0] pending_vec;
    modport master (
        output int_sources, int_enable, ea, edge_mode, int_ack_attended, int_ack_complete,
        input int_req, int_number, int_pending, int_attending, pending_vec
    );
    modport slave (
        input int_sources, int_enable, ea, edge_mode, int_ack_attended, int_ack_complete,
        output int_req, int_number, int_pending, int_attending, pending_vec
    );
endinterface

// File: rtl/interrupt_controller_n.sv
// interrupt_controller_n: N-source fixed-priority interrupt controller with attended/complete handshake
module interrupt_controller_n #(
    parameter int NUM_SRC = 8,
    parameter int IDW = $clog2(NUM_SRC)
) (
    input logic clk,
    input logic rst,
    interrupt_controller_n_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state, state_n;
    logic [NUM_SRC-1:0] masked, hist, eligible, clr, pend_n, onehot;
    logic [IDW-1:0] sel, num_n;
    logic req_n, att_n, any_n;
    assign masked = bus.int_sources & bus.int_enable & {NUM_SRC{bus.ea}};
    assign eligible = bus.pending_vec & bus.int_enable & {NUM_SRC{bus.ea}};
    assign onehot = NUM_SRC'(1) << bus.int_number;
    // lowest eligible index wins
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) sel = IDW'(i);
    end
    // next state, next outputs and pending-bit update
    always_comb begin
        state_n = state;
        req_n = bus.int_req;
        num_n = bus.int_number;
        att_n = bus.int_attending;
        clr = '0;
        case (state)
            IDLE: if (|eligible) begin
                state_n = REQ;
                req_n = 1'b1;
                num_n = sel;
            end
            REQ: if (bus.int_ack_attended) begin
                state_n = SERVICE;
                req_n = 1'b0;
                att_n = 1'b1;
                clr = onehot & bus.edge_mode;
            end
            SERVICE: if (bus.int_ack_complete) begin
                state_n = IDLE;
                att_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        pend_n = (bus.edge_mode & ((masked & ~hist) | (bus.pending_vec & ~clr))) | (~bus.edge_mode & masked);
        any_n = (state == IDLE) ? |eligible : |(eligible & ~onehot);
    end
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hist <= '0;
            bus.pending_vec <= '0;
            bus.int_req <= 1'b0;
            bus.int_number <= '0;
            bus.int_pending <= 1'b0;
            bus.int_attending <= 1'b0;
        end else begin
            state <= state_n;
            hist <= masked;
            bus.pending_vec <= pend_n;
            bus.int_req <= req_n;
            bus.int_number <= num_n;
            bus.int_pending <= any_n;
            bus.int_attending <= att_n;
        end
    end
endmodule

// File: tb/tb_interrupt_controller_n.sv
// tb_interrupt_controller_n: directed vector table plus corner-case sequences for interrupt_controller_n
module tb_interrupt_controller_n;
    logic clk, rst;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [7:0] src;
        logic [1:0] ack;
        logic req;
        logic [2:0] num;
        logic [1:0] pa;
        logic [7:0] pvec;
    } vec_t;
    vec_t tbl[21];
    interrupt_controller_n_if #(.NUM_SRC(8)) b();
    interrupt_controller_n #(.NUM_SRC(8)) dut (.clk(clk), .rst(rst), .bus(b));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    function automatic logic [13:0] outs();
        return {b.int_req, b.int_number, b.int_pending, b.int_attending, b.pending_vec};
    endfunction
    task automatic pulse_att();
        b.int_ack_attended = 1'b1;
        tick();
        b.int_ack_attended = 1'b0;
    endtask
    task automatic pulse_cmp();
        b.int_ack_complete = 1'b1;
        tick();
        b.int_ack_complete = 1'b0;
    endtask
    initial begin
        tbl[0]  = '{8'h00, 2'b00, 1'b0, 3'd0, 2'b00, 8'h00};
        tbl[1]  = '{8'h20, 2'b00, 1'b0, 3'd0, 2'b00, 8'h20};
        tbl[2]  = '{8'h00, 2'b00, 1'b1, 3'd5, 2'b10, 8'h20};
        tbl[3]  = '{8'h00, 2'b00, 1'b1, 3'd5, 2'b00, 8'h20};
        tbl[4]  = '{8'h00, 2'b10, 1'b0, 3'd5, 2'b01, 8'h00};
        tbl[5]  = '{8'h00, 2'b00, 1'b0, 3'd5, 2'b01, 8'h00};
        tbl[6]  = '{8'h00, 2'b01, 1'b0, 3'd5, 2'b00, 8'h00};
        tbl[7]  = '{8'h00, 2'b00, 1'b0, 3'd5, 2'b00, 8'h00};
        tbl[8]  = '{8'h00, 2'b01, 1'b0, 3'd5, 2'b00, 8'h00};
        tbl[9]  = '{8'h00, 2'b10, 1'b0, 3'd5, 2'b00, 8'h00};
        tbl[10] = '{8'h44, 2'b00, 1'b0, 3'd5, 2'b00, 8'h44};
        tbl[11] = '{8'h44, 2'b00, 1'b1, 3'd2, 2'b10, 8'h44};
        tbl[12] = '{8'h00, 2'b00, 1'b1, 3'd2, 2'b10, 8'h44};
        tbl[13] = '{8'h00, 2'b10, 1'b0, 3'd2, 2'b11, 8'h40};
        tbl[14] = '{8'h00, 2'b10, 1'b0, 3'd2, 2'b11, 8'h40};
        tbl[15] = '{8'h00, 2'b01, 1'b0, 3'd2, 2'b10, 8'h40};
        tbl[16] = '{8'h00, 2'b00, 1'b1, 3'd6, 2'b10, 8'h40};
        tbl[17] = '{8'h00, 2'b00, 1'b1, 3'd6, 2'b00, 8'h40};
        tbl[18] = '{8'h00, 2'b10, 1'b0, 3'd6, 2'b01, 8'h00};
        tbl[19] = '{8'h00, 2'b01, 1'b0, 3'd6, 2'b00, 8'h00};
        tbl[20] = '{8'h00, 2'b00, 1'b0, 3'd6, 2'b00, 8'h00};
        rst = 1'b1;
        b.int_sources = '0;
        b.int_enable = 8'hFF;
        b.ea = 1'b1;
        b.edge_mode = 8'hFF;
        b.int_ack_attended = 1'b0;
        b.int_ack_complete = 1'b0;
        tick();
        tick();
        chk("reset", 32'(outs()), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            b.int_sources = tbl[i].src;
            {b.int_ack_attended, b.int_ack_complete} = tbl[i].ack;
            tick();
            chk($sformatf("row%0d", i), 32'(outs()),
                32'({tbl[i].req, tbl[i].num, tbl[i].pa, tbl[i].pvec}));
        end
        b.int_ack_attended = 1'b0;
        b.int_ack_complete = 1'b0;
        b.edge_mode = 8'hFD;
        b.int_sources = 8'h02;
        tick();
        chk("lvl_pvec", 32'(b.pending_vec), 32'h02);
        tick();
        chk("lvl_req", 32'({b.int_req, b.int_number}), 32'({1'b1, 3'd1}));
        pulse_att();
        chk("lvl_serv", 32'({b.int_attending, b.int_req, b.pending_vec}), 32'({2'b10, 8'h02}));
        pulse_cmp();
        tick();
        chk("lvl_rereq", 32'({b.int_req, b.int_number}), 32'({1'b1, 3'd1}));
        pulse_att();
        b.int_sources = 8'h00;
        tick();
        chk("lvl_drop", 32'(b.pending_vec), 32'h0);
        pulse_cmp();
        tick();
        tick();
        chk("lvl_idle", 32'({b.int_req, b.int_attending, b.pending_vec}), 32'h0);
        b.edge_mode = 8'hFF;
        b.ea = 1'b0;
        b.int_sources = 8'h08;
        tick();
        b.int_sources = 8'h00;
        tick();
        tick();
        chk("ea_off", 32'({b.int_req, b.pending_vec}), 32'h0);
        b.ea = 1'b1;
        tick();
        b.int_sources = 8'h10;
        tick();
        b.int_sources = 8'h00;
        b.int_enable = 8'hEF;
        chk("en_set", 32'(b.pending_vec), 32'h10);
        tick();
        tick();
        chk("en_keep", 32'({b.int_req, b.pending_vec}), 32'({1'b0, 8'h10}));
        b.int_enable = 8'hFF;
        tick();
        chk("en_req", 32'({b.int_req, b.int_number}), 32'({1'b1, 3'd4}));
        pulse_att();
        pulse_cmp();
        tick();
        b.int_sources = 8'h01;
        tick();
        b.int_sources = 8'h00;
        tick();
        chk("rt_req", 32'({b.int_req, b.int_number}), 32'({1'b1, 3'd0}));
        pulse_att();
        b.int_sources = 8'h01;
        tick();
        b.int_sources = 8'h00;
        chk("rt_pvec", 32'({b.int_attending, b.pending_vec}), 32'({1'b1, 8'h01}));
        pulse_cmp();
        tick();
        chk("rt_rereq", 32'({b.int_req, b.int_number}), 32'({1'b1, 3'd0}));
        pulse_att();
        pulse_cmp();
        tick();
        b.int_sources = 8'h80;
        tick();
        b.int_sources = 8'h00;
        b.int_ack_complete = 1'b1;
        tick();
        b.int_ack_complete = 1'b0;
        chk("rs_req", 32'({b.int_req, b.int_number, b.int_attending}), 32'({1'b1, 3'd7, 1'b0}));
        rst = 1'b1;
        tick();
        chk("rs_zero", 32'(outs()), 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("rs_after", 32'(outs()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
